// File: rtl/hidden_cpu_pkg.sv
// hidden_cpu_pkg: shared state encoding and instruction constants for the HiddenCPU slice
package hidden_cpu_pkg;
  typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam int INSTR_W = 6;
  localparam logic [INSTR_W-1:0] IDLE_INSTR = 6'b000000;
endpackage

// File: rtl/prog_mem.sv
// prog_mem: DEPTH x IW register array, one synchronous write port, one combinational read port
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int IW = 6
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [IW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [IW-1:0]            rdata
);
  logic [IW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/hidden_prog_feeder.sv
// hidden_prog_feeder: loads a program then replays it in lock-step with the core PC; FEEDER_LOOP_EN makes the program loop
module hidden_prog_feeder
  import hidden_cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW = INSTR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic [IW-1:0]            load_data,
  output logic                     load_ready,
  input  logic                     start,
  input  logic                     halt,
  input  logic                     clear,
  input  logic [7:0]               pc_in,
  input  logic                     pc_in_valid,
  output logic [IW-1:0]            instr_out,
  output logic                     instr_valid,
  output logic [1:0]               state_out,
  output logic [$clog2(DEPTH):0]   prog_len
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  state_t state, state_n;
  logic [AW-1:0] rd_ptr, ptr_n, raddr;
  logic [LW-1:0] len_n, len_acc, nxt;
  logic [IW-1:0] out_n, rdata;
  logic valid_n, accept, go, in_range;
  prog_mem #(.DEPTH(DEPTH), .IW(IW)) u_mem (
    .clk(clk), .we(accept), .waddr(prog_len[AW-1:0]), .wdata(load_data),
    .raddr(raddr), .rdata(rdata)
  );
  assign load_ready = state == ST_LOAD && prog_len < LW'(DEPTH);
  assign state_out = state;
  always_comb begin
    accept = state == ST_LOAD && load_valid && load_ready && !clear;
    len_acc = prog_len + LW'(accept);
    go = start && (state != ST_LOAD || len_acc != '0);
    nxt = pc_in_valid ? LW'(9'(pc_in) % 9'(DEPTH)) : LW'(rd_ptr) + LW'(1);
    in_range = nxt < prog_len;
    raddr = (go || !in_range) ? '0 : nxt[AW-1:0];
    state_n = state;
    len_n = prog_len;
    ptr_n = rd_ptr;
    out_n = instr_out;
    valid_n = instr_valid;
    if (clear) begin
      state_n = ST_LOAD;
      len_n = '0;
      ptr_n = '0;
      out_n = IW'(IDLE_INSTR);
      valid_n = 1'b0;
    end else if (halt && state == ST_RUN) begin
      state_n = ST_DONE;
      out_n = IW'(IDLE_INSTR);
      valid_n = 1'b0;
    end else if (go) begin
      // a word accepted into an empty memory is not yet readable, so bypass it
      state_n = ST_RUN;
      len_n = len_acc;
      ptr_n = '0;
      out_n = prog_len == '0 ? load_data : rdata;
      valid_n = 1'b1;
    end else if (state == ST_LOAD) begin
      len_n = len_acc;
    end else if (state == ST_RUN) begin
      if (in_range) begin
        ptr_n = nxt[AW-1:0];
        out_n = rdata;
      end else begin
`ifdef FEEDER_LOOP_EN
        ptr_n = '0;
        out_n = rdata;
`else
        state_n = ST_DONE;
        out_n = IW'(IDLE_INSTR);
        valid_n = 1'b0;
`endif
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_LOAD;
      prog_len <= '0;
      rd_ptr <= '0;
      instr_out <= IW'(IDLE_INSTR);
      instr_valid <= 1'b0;
    end else begin
      state <= state_n;
      prog_len <= len_n;
      rd_ptr <= ptr_n;
      instr_out <= out_n;
      instr_valid <= valid_n;
    end
endmodule

// File: tb/tb_hidden_prog_feeder.sv
// tb_hidden_prog_feeder: table-driven directed checks for hidden_prog_feeder (DEPTH=16), either FEEDER_LOOP_EN setting
module tb_hidden_prog_feeder;
`ifdef FEEDER_LOOP_EN
  localparam bit L = 1'b1;
`else
  localparam bit L = 1'b0;
`endif
  logic clk = 0, rst = 1, load_valid = 0, start = 0, halt = 0, clear = 0, pc_in_valid = 0;
  logic [5:0] load_data = 0;
  logic [7:0] pc_in = 0;
  logic load_ready, instr_valid;
  logic [5:0] instr_out;
  logic [1:0] state_out;
  logic [4:0] prog_len;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    bit lv; logic [5:0] ld; bit st, ht, cl, pcv; logic [7:0] pc;
    int e_state, e_valid, e_instr, e_len;
  } vec_t;
  vec_t vecs[$];
  hidden_prog_feeder #(.DEPTH(16), .IW(6)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .start(start), .halt(halt), .clear(clear), .pc_in(pc_in), .pc_in_valid(pc_in_valid),
    .instr_out(instr_out), .instr_valid(instr_valid), .state_out(state_out), .prog_len(prog_len)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(bit lv, int ld, bit st, bit ht, bit cl, bit pcv, int pc,
                              int es, int ev, int ei, int el);
    vec_t v;
    v.lv = lv; v.ld = 6'(ld); v.st = st; v.ht = ht; v.cl = cl; v.pcv = pcv; v.pc = 8'(pc);
    v.e_state = es; v.e_valid = ev; v.e_instr = ei; v.e_len = el;
    return v;
  endfunction
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_all(string tag, int es, int ev, int ei, int el);
    chk({tag, " state"}, state_out, es);
    chk({tag, " valid"}, instr_valid, ev);
    chk({tag, " instr"}, instr_out, ei);
    chk({tag, " len"}, prog_len, el);
    chk({tag, " ready"}, load_ready, (es == 0 && el < 16) ? 1 : 0);
  endtask
  task automatic drive(bit lv, int ld, bit st, bit ht, bit cl, bit pcv, int pc);
    load_valid = lv; load_data = 6'(ld); start = st; halt = ht; clear = cl;
    pc_in_valid = pcv; pc_in = 8'(pc);
    @(posedge clk); #1;
    load_valid = 0; start = 0; halt = 0; clear = 0; pc_in_valid = 0;
  endtask
  initial begin
    vecs.push_back(mk(1, 'h11, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 'h22, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 'h33, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 'h11, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h22, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h33, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, L ? 1 : 2, L, L ? 'h11 : 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 'h11, 3));
    vecs.push_back(mk(1, 'h3F, 0, 0, 0, 0, 0, 1, 1, 'h22, 3));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 2, 0, 0, 3));
    vecs.push_back(mk(1, 'h05, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h05, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h2A, 1, 0, 0, 0, 0, 1, 1, 'h2A, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, L ? 1 : 2, L, L ? 'h2A : 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 'h20 + i, 0, 0, 0, 0, 0, 0, 0, 0, i + 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 'h20, 8));
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h20 + i, 8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h12, 1, 1, 'h22, 8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h23, 8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h0A, L ? 1 : 2, L, L ? 'h20 : 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 'h10 + i, 0, 0, 0, 0, 0, 0, 0, 0, i + 1));
    vecs.push_back(mk(1, 'h3F, 0, 0, 0, 0, 0, 0, 0, 0, 16));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 'h10, 16));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h0F, 1, 1, 'h1F, 16));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, L ? 1 : 2, L, L ? 'h10 : 0, 16));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 'h05, 1, 1, 'h10, 16));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 'h05, 2, 0, 0, 16));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_all("reset", 0, 0, 0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].lv, vecs[i].ld, vecs[i].st, vecs[i].ht, vecs[i].cl, vecs[i].pcv, vecs[i].pc);
      chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_len);
    end
    drive(1, 'h15, 0, 0, 0, 0, 0);
    drive(1, 'h16, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    chk_all("seq start", 1, 1, 'h15, 2);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk_all("seq clear", 0, 0, 0, 0);
    drive(1, 'h17, 1, 0, 0, 0, 0);
    chk_all("seq restart", 1, 1, 'h17, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_all("seq rst", 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
